hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/sb_match.sv | 40 ++++
 rtl/hazard_scoreboard.sv | 117 +++++++++++
 tb/tb_hazard_scoreboard.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg -- definitions shared by the hazard scoreboard and its comparator.
//   SB_RD_W     : stored width of a destination index. A source index is
//                 zero-extended to this width, so NREGS may be at most 256.
//   FWD_REGFILE : forward-select code meaning "read the register file".
//   sb_entry_t  : one in-flight instruction {valid, rd, we, is_load}.
//   idx_width() : index width for N items (clog2, at least 1 bit).
package cpu_pkg;

  localparam int SB_RD_W     = 8;
  localparam int FWD_REGFILE = 0;

  typedef struct packed {
    logic               valid;
    logic [SB_RD_W-1:0] rd;
    logic               we;
    logic               is_load;
  } sb_entry_t;

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sb_match.sv
// sb_match -- compares one decode source against every scoreboard slot and
// reports the youngest producer, which is the lowest slot index.
//   tbl_i     : in-flight table, where slot 0 is EX
//   src_i     : source register index
//   used_i    : the instruction actually reads this source
//   hit_o     : some slot will write src_i (x0 never matches)
//   slot_o    : index of the youngest matching slot
//   is_load_o : that youngest producer is a load
module sb_match
  import cpu_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int RAW   = 5,
  parameter int FW    = 2
) (
  input  sb_entry_t        tbl_i [DEPTH],
  input  logic [RAW-1:0]   src_i,
  input  logic             used_i,
  output logic             hit_o,
  output logic [FW-1:0]    slot_o,
  output logic             is_load_o
);

  // The loop scans from oldest to youngest. Each later match overwrites the
  // earlier one, so the lowest matching slot is the one that remains.
  always_comb begin
    hit_o     = 1'b0;
    slot_o    = '0;
    is_load_o = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (tbl_i[k].valid && tbl_i[k].we && used_i && (src_i != '0) &&
          (tbl_i[k].rd == SB_RD_W'(src_i))) begin
        hit_o     = 1'b1;
        slot_o    = FW'(k);
        is_load_o = tbl_i[k].is_load;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard -- tracks in-flight destinations from EX through
// writeback. It stalls decode on RAW hazards and selects forwarding sources.
// Build option: define HAZARD_FORWARDING_EN to enable forwarding. When it is
// enabled, only a young load stalls decode. When it is undefined, any
// in-flight producer stalls decode until it retires, and the forward
// selects stay 0.
//   clk, reset                    : clock and synchronous active-high reset
//   id_valid                      : decode holds a real instruction
//   id_rs1/2, id_rs1/2_used       : source indices and their read flags
//   id_rd, id_rd_we, id_is_load   : destination description
//   redirect                      : taken branch resolved in EX; the decode
//                                   instruction is squashed
//   pc_enable, ifid_enable        : front-end advance enables
//   idex_bubble                   : insert a NOP into ID/EX
//   fwd_rs1_sel, fwd_rs2_sel      : 0 = register file, k = slot k-1 result
//   stall_count                   : saturating count of stall cycles
module hazard_scoreboard
  import cpu_pkg::*;
#(
  parameter  int NREGS    = 32,
  parameter  int DEPTH    = 3,
  parameter  int LOAD_LAT = 2,
  localparam int RAW      = idx_width(NREGS),
  localparam int FW       = idx_width(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           id_valid,
  input  logic [RAW-1:0] id_rs1,
  input  logic [RAW-1:0] id_rs2,
  input  logic           id_rs1_used,
  input  logic           id_rs2_used,
  input  logic [RAW-1:0] id_rd,
  input  logic           id_rd_we,
  input  logic           id_is_load,
  input  logic           redirect,
  output logic           pc_enable,
  output logic           ifid_enable,
  output logic           idex_bubble,
  output logic [FW-1:0]  fwd_rs1_sel,
  output logic [FW-1:0]  fwd_rs2_sel,
  output logic [31:0]    stall_count
);

  sb_entry_t     table_q [DEPTH];
  sb_entry_t     table_d [DEPTH];
  logic [31:0]   stall_cnt_q, stall_cnt_d;

  logic          hit1, hit2, ld1, ld2, haz1, haz2, stall;
  logic [FW-1:0] slot1, slot2;

  sb_match #(.DEPTH(DEPTH), .RAW(RAW), .FW(FW)) u_match_rs1 (
    .tbl_i(table_q), .src_i(id_rs1), .used_i(id_rs1_used),
    .hit_o(hit1), .slot_o(slot1), .is_load_o(ld1)
  );

  sb_match #(.DEPTH(DEPTH), .RAW(RAW), .FW(FW)) u_match_rs2 (
    .tbl_i(table_q), .src_i(id_rs2), .used_i(id_rs2_used),
    .hit_o(hit2), .slot_o(slot2), .is_load_o(ld2)
  );

`ifdef HAZARD_FORWARDING_EN
  // A load result can be forwarded once the load has reached slot
  // LOAD_LAT-1. Before that slot, a load producer forces a stall.
  localparam logic [FW-1:0] LD_READY = FW'(LOAD_LAT - 1);

  assign haz1 = hit1 && ld1 && (slot1 < LD_READY);
  assign haz2 = hit2 && ld2 && (slot2 < LD_READY);

  // The select is zero when decode is empty or stalled.
  assign fwd_rs1_sel = (id_valid && !stall && hit1) ? slot1 + FW'(1) : FW'(FWD_REGFILE);
  assign fwd_rs2_sel = (id_valid && !stall && hit2) ? slot2 + FW'(1) : FW'(FWD_REGFILE);
`else
  logic unused_fwd_info;
  assign unused_fwd_info = ^{slot1, slot2, ld1, ld2, (LOAD_LAT > 0)};

  assign haz1        = hit1;
  assign haz2        = hit2;
  assign fwd_rs1_sel = FW'(FWD_REGFILE);
  assign fwd_rs2_sel = FW'(FWD_REGFILE);
`endif

  // Redirect squashes the decode instruction. A squashed instruction cannot
  // stall, but it still needs a bubble behind the branch.
  assign stall       = id_valid && !redirect && (haz1 || haz2);
  assign pc_enable   = !stall;
  assign ifid_enable = !stall;
  assign idex_bubble = stall || redirect;
  assign stall_count = stall_cnt_q;

  always_comb begin
    table_d[0] = '0;
    if (id_valid && !stall && !redirect) begin
      table_d[0].valid   = 1'b1;
      table_d[0].rd      = SB_RD_W'(id_rd);
      table_d[0].we      = id_rd_we;
      table_d[0].is_load = id_is_load;
    end
    for (int k = 1; k < DEPTH; k++) table_d[k] = table_q[k-1];
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) table_q[k] <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) table_q[k] <= table_d[k];
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard -- directed test of hazard_scoreboard with its default
// parameters (NREGS=32, DEPTH=3, LOAD_LAT=2). Expected values follow
// HAZARD_FORWARDING_EN in the same way the design does.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_rs1_used, id_rs2_used, id_rd_we, id_is_load;
  logic        redirect;
  logic        pc_enable, ifid_enable, idex_bubble;
  logic [1:0]  fwd_rs1_sel, fwd_rs2_sel;
  logic [31:0] stall_count;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_cnt = 32'd0;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_rd_we(id_rd_we), .id_is_load(id_is_load),
    .redirect(redirect),
    .pc_enable(pc_enable), .ifid_enable(ifid_enable), .idex_bubble(idex_bubble),
    .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel),
    .stall_count(stall_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic pc, input logic bub,
                         input logic [1:0] f1, input logic [1:0] f2);
    chk({tag, ".pc_enable"},   32'(pc_enable),   32'(pc));
    chk({tag, ".ifid_enable"}, 32'(ifid_enable), 32'(pc));
    chk({tag, ".idex_bubble"}, 32'(idex_bubble), 32'(bub));
    chk({tag, ".fwd_rs1"},     32'(fwd_rs1_sel), 32'(f1));
    chk({tag, ".fwd_rs2"},     32'(fwd_rs2_sel), 32'(f2));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    id_rd = 0; id_rd_we = 0; id_is_load = 0; redirect = 0;
    #1;
  endtask

  task automatic dec(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                     input logic u2, input logic [4:0] rd, input logic we, input logic ld);
    id_valid = 1; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
    id_rd = rd; id_rd_we = we; id_is_load = ld;
    #1;
  endtask

  task automatic drain();
    idle();
    repeat (3) tick();
  endtask

  initial begin
    // Reset and the empty-table outputs.
    reset = 1;
    idle();
    tick();
    chk_out("reset_hold", 1, 0, 0, 0);
    tick();
    chk("reset_cnt", stall_count, 32'd0);
    reset = 0;
    #1;
    chk_out("post_reset", 1, 0, 0, 0);

    // ALU producer x5 followed by add x6,x5,x5.
    dec(5'd1, 1, 5'd2, 1, 5'd5, 1, 0);
    chk_out("alu_prod", 1, 0, 0, 0);
    tick();
    dec(5'd5, 1, 5'd5, 1, 5'd6, 1, 0);
`ifdef HAZARD_FORWARDING_EN
    chk_out("alu_use_fwd", 1, 0, 2'd1, 2'd1);
    tick();
`else
    for (int i = 0; i < 3; i++) begin
      chk_out("alu_use_stall", 0, 1, 0, 0);
      tick();
    end
    chk_out("alu_use_free", 1, 0, 0, 0);
    tick();
    exp_cnt = exp_cnt + 32'd3;
`endif
    chk("alu_cnt", stall_count, exp_cnt);
    drain();

    // lw x7 followed by add x8,x7,x0.
    dec(5'd0, 0, 5'd0, 0, 5'd7, 1, 1);
    tick();
    dec(5'd7, 1, 5'd0, 1, 5'd8, 1, 0);
`ifdef HAZARD_FORWARDING_EN
    chk_out("load_use_stall", 0, 1, 0, 0);
    tick();
    chk_out("load_use_fwd", 1, 0, 2'd2, 2'd0);
    tick();
    exp_cnt = exp_cnt + 32'd1;
`else
    for (int i = 0; i < 3; i++) begin
      chk_out("load_use_stall", 0, 1, 0, 0);
      tick();
    end
    chk_out("load_use_free", 1, 0, 0, 0);
    tick();
    exp_cnt = exp_cnt + 32'd3;
`endif
    chk("load_cnt", stall_count, exp_cnt);
    drain();

    // A redirect squashes the dependent add x8,x7.
    dec(5'd0, 0, 5'd0, 0, 5'd7, 1, 1);
    tick();
    dec(5'd7, 1, 5'd0, 0, 5'd8, 1, 0);
    redirect = 1;
    #1;
`ifdef HAZARD_FORWARDING_EN
    chk_out("redirect", 1, 1, 2'd1, 0);
`else
    chk_out("redirect", 1, 1, 0, 0);
`endif
    tick();
    redirect = 0;
    dec(5'd8, 1, 5'd0, 0, 5'd0, 0, 0);
    chk_out("squashed_x8", 1, 0, 0, 0);
    dec(5'd8, 1, 5'd7, 1, 5'd0, 0, 0);
`ifdef HAZARD_FORWARDING_EN
    chk_out("load_slot1", 1, 0, 0, 2'd2);
`else
    chk_out("load_slot1", 0, 1, 0, 0);
`endif
    chk("redirect_cnt", stall_count, exp_cnt);
    drain();

    // A write to x0 never creates a dependency.
    dec(5'd0, 0, 5'd0, 0, 5'd0, 1, 0);
    tick();
    dec(5'd0, 1, 5'd0, 1, 5'd3, 1, 0);
    chk_out("x0_use", 1, 0, 0, 0);
    idle();
    tick();

    // Two producers of x9: the younger one in slot 0 wins.
    dec(5'd0, 0, 5'd0, 0, 5'd9, 1, 0);
    tick();
    dec(5'd0, 0, 5'd0, 0, 5'd9, 1, 0);
    tick();
    dec(5'd9, 1, 5'd3, 1, 5'd4, 1, 0);
`ifdef HAZARD_FORWARDING_EN
    chk_out("youngest_x9", 1, 0, 2'd1, 0);
`else
    chk_out("youngest_x9", 0, 1, 0, 0);
`endif
    dec(5'd9, 0, 5'd9, 0, 5'd4, 1, 0);
    chk_out("unused_src", 1, 0, 0, 0);
    dec(5'd9, 1, 5'd9, 1, 5'd4, 1, 0);
    id_valid = 0;
    #1;
    chk_out("no_valid", 1, 0, 0, 0);
    drain();

    // Saturation: the counter steps to FFFF_FFFF and then holds there.
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    #1;
    chk("forced_cnt", stall_count, 32'hFFFF_FFFE);
    dec(5'd0, 0, 5'd0, 0, 5'd7, 1, 1);
    tick();
    dec(5'd7, 1, 5'd0, 0, 5'd8, 1, 0);
    chk_out("sat_stall_a", 0, 1, 0, 0);
    tick();
    chk("sat_reach", stall_count, 32'hFFFF_FFFF);
    drain();
    dec(5'd0, 0, 5'd0, 0, 5'd7, 1, 1);
    tick();
    dec(5'd7, 1, 5'd0, 0, 5'd8, 1, 0);
    chk_out("sat_stall_b", 0, 1, 0, 0);
    tick();
    chk("sat_hold", stall_count, 32'hFFFF_FFFF);
    drain();

    // Reset while a stall is active: the table empties and the stall drops.
    dec(5'd0, 0, 5'd0, 0, 5'd7, 1, 1);
    tick();
    dec(5'd7, 1, 5'd0, 0, 5'd8, 1, 0);
    chk_out("pre_reset_stall", 0, 1, 0, 0);
    reset = 1;
    tick();
    chk("reset_mid_cnt", stall_count, 32'd0);
    reset = 0;
    #1;
    chk_out("after_reset_use", 1, 0, 0, 0);
    tick();
    chk("after_reset_cnt", stall_count, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
